// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage with ALU, status register, branch target and EXE/MEM register (EXE_SHIFT_EN adds register barrel shifter)
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_STALL,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic [3:0]  EXE_CMD_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] VAL_RN_IN,
  input  logic [31:0] VAL_RM_IN,
  input  logic        IMM_IN,
  input  logic [11:0] SHIFT_OPERAND_IN,
  input  logic [23:0] SIGNED_IMM_24_IN,
  input  logic [3:0]  DEST_IN,
  output logic [3:0]  SR,
  output logic        BRANCH_TAKEN,
  output logic [31:0] BRANCH_ADDR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_RES,
  output logic [31:0] VAL_RM,
  output logic [3:0]  DEST
);
  logic [31:0] imm8, imm_rot, shifted, val2, opb, res;
  logic [32:0] sum;
  logic [4:0]  rot;
  logic        arith, sub, cin, c_n, v_n;
`ifdef EXE_SHIFT_EN
  logic [4:0]  sh;
`endif
  always_comb begin
    imm8 = {24'b0, SHIFT_OPERAND_IN[7:0]};
    rot = {SHIFT_OPERAND_IN[11:8], 1'b0};
    imm_rot = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
`ifdef EXE_SHIFT_EN
    sh = SHIFT_OPERAND_IN[11:7];
    shifted = SHIFT_OPERAND_IN[6:5] == 2'b00 ? VAL_RM_IN << sh :
              SHIFT_OPERAND_IN[6:5] == 2'b01 ? VAL_RM_IN >> sh :
              SHIFT_OPERAND_IN[6:5] == 2'b10 ? 32'($signed(VAL_RM_IN) >>> sh) :
              (VAL_RM_IN >> sh) | (VAL_RM_IN << (6'd32 - {1'b0, sh}));
`else
    shifted = VAL_RM_IN;
`endif
    val2 = (MEM_R_EN_IN | MEM_W_EN_IN) ? {20'b0, SHIFT_OPERAND_IN} : IMM_IN ? imm_rot : shifted;
    arith = EXE_CMD_IN[3:1] == 3'b001 || EXE_CMD_IN[3:1] == 3'b010;
    sub = EXE_CMD_IN[3:1] == 3'b010;
    opb = sub ? ~val2 : val2;
    cin = EXE_CMD_IN[0] ? SR[1] : sub;
    sum = {1'b0, VAL_RN_IN} + {1'b0, opb} + {32'b0, cin};
    res = EXE_CMD_IN == 4'b0001 ? val2 :
          EXE_CMD_IN == 4'b1001 ? ~val2 :
          arith ? sum[31:0] :
          EXE_CMD_IN == 4'b0110 ? VAL_RN_IN & val2 :
          EXE_CMD_IN == 4'b0111 ? VAL_RN_IN | val2 :
          EXE_CMD_IN == 4'b1000 ? VAL_RN_IN ^ val2 : 32'b0;
    c_n = arith ? sum[32] : SR[1];
    v_n = arith ? (VAL_RN_IN[31] == opb[31]) && (sum[31] != VAL_RN_IN[31]) : SR[0];
  end
  assign BRANCH_TAKEN = B_IN;
  assign BRANCH_ADDR = PC_IN + {{6{SIGNED_IMM_24_IN[23]}}, SIGNED_IMM_24_IN, 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      SR <= '0;
      WB_EN <= 1'b0;
      MEM_R_EN <= 1'b0;
      MEM_W_EN <= 1'b0;
      ALU_RES <= '0;
      VAL_RM <= '0;
      DEST <= '0;
    end else if (!MEM_STALL) begin
      WB_EN <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      MEM_W_EN <= MEM_W_EN_IN;
      ALU_RES <= res;
      VAL_RM <= VAL_RM_IN;
      DEST <= DEST_IN;
      if (S_IN) SR <= {res[31], res == 32'b0, c_n, v_n};
    end
  end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM-subset pipeline and the consumer of the ID/EX pipeline register. It computes the ALU result and branch target from the registered decode outputs. It owns the architectural status register, which it feeds back to the ID stage as the `SR` input of the ID/EX register. It latches its results into its own EXE/MEM register, and that register holds while memory stalls.

## Interface
- No parameters.
- `clk  in  1` — pipeline clock; all state updates on rising edge.
- `rst  in  1` — reset. One clock; reset is synchronous and active-high.
- `MEM_STALL  in  1` — memory stage busy; freezes all state in this block.
- `WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN  in  1 each` — control bits from ID/EX.
- `EXE_CMD_IN  in  4` — ALU opcode.
- `PC_IN  in  32` — PC+4 of the instruction.
- `VAL_RN_IN, VAL_RM_IN  in  32 each` — register operands.
- `IMM_IN  in  1` — operand 2 is immediate.
- `SHIFT_OPERAND_IN  in  12` — ARM shifter operand field.
- `SIGNED_IMM_24_IN  in  24` — branch offset in words.
- `DEST_IN  in  4` — destination register.
- `SR  out  4` — status register {N,Z,C,V}, registered.
- `BRANCH_TAKEN  out  1` — combinational copy of `B_IN`; flushes IF/ID.
- `BRANCH_ADDR  out  32` — combinational branch target.
- `WB_EN, MEM_R_EN, MEM_W_EN  out  1 each` — EXE/MEM register.
- `ALU_RES  out  32` — EXE/MEM register.
- `VAL_RM  out  32` — store data, EXE/MEM register.
- `DEST  out  4` — EXE/MEM register.

## Operation
- Val2 selection, in priority order:
  - `MEM_R_EN_IN | MEM_W_EN_IN`: `{20'b0, SHIFT_OPERAND_IN}`.
  - `IMM_IN=1`: `{24'b0, op[7:0]}` rotated right by `2*op[11:8]`.
  - Otherwise: `VAL_RM_IN` shifted by `op[11:7]` using type `op[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR). Shift amount 0 means no shift.
- EXE_CMD encoding; C is the current `SR[1]`:
  - 0001 MOV = Val2.
  - 1001 MVN = ~Val2.
  - 0010 ADD = Rn+Val2.
  - 0011 ADC = Rn+Val2+C.
  - 0100 SUB = Rn−Val2.
  - 0101 SBC = Rn−Val2−!C.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code gives result 0.
- Arithmetic is 33-bit internally.
  - ADD/ADC: C = bit 32.
  - SUB/SBC: C = NOT borrow, ARM convention.
  - V = signed overflow of the 32-bit result.
  - Logic ops and MOV/MVN: C and V keep their current SR values.
- N = result[31]; Z = (result == 0).
- Status update: on a rising edge with `S_IN=1` and `MEM_STALL=0`, `SR <= {N,Z,C,V}`; otherwise SR holds.
- Branch: `BRANCH_ADDR = PC_IN + (sext(SIGNED_IMM_24_IN) << 2)`, computed in 32 bits, wrap-around ignored. `BRANCH_TAKEN = B_IN`. Both are purely combinational.
- EXE/MEM register: on a rising edge with `MEM_STALL=0`, captures WB_EN/MEM_R_EN/MEM_W_EN/DEST from the inputs, the ALU result, and `VAL_RM_IN`. With `MEM_STALL=1`, every register holds.

## Timing
- Reset, synchronous: `SR`, `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `ALU_RES`, `VAL_RM`, `DEST` all become 0 at the first rising edge with `rst=1`. Reset overrides `MEM_STALL`.
- Latency:
  - EXE/MEM outputs reflect inputs presented in cycle N after edge N+1.
  - An SR update from cycle N is visible to the next instruction (ADC/SBC) in cycle N+1.
- Back-to-back flag-dependent ops (S then ADC) therefore use the updated carry without bubbles.
- `BRANCH_TAKEN`/`BRANCH_ADDR` are valid in the same cycle as the ID/EX outputs. They are not gated by `MEM_STALL`; upstream gates the flush.
- Stall boundary:
  - While stalled, the input instruction must be held by upstream.
  - On the first cycle with `MEM_STALL=0`, the held instruction is captured exactly once and SR is updated once.
- `S_IN=1` together with `MEM_STALL=1`: SR does not change until the stall clears.

## Configuration
- Macro `EXE_SHIFT_EN`.
- Defined: the full register-operand barrel shifter (LSL/LSR/ASR/ROR by `op[11:7]`) is present.
- Undefined: for `IMM_IN=0` non-memory instructions, Val2 = `VAL_RM_IN` unshifted and `op[11:5]` is ignored. Immediate rotation and memory offsets are unchanged.

## Test plan
- Reset: drive `rst=1` for one edge with nonzero inputs -> all registered outputs and `SR` are 0 after that edge.
- Carry/zero: ADD, S=1, Rn=0xFFFFFFFF, IMM=1, op=0x001 -> next edge `ALU_RES`=0x00000000, `SR`=4'b0110. Then ADC Rn=0, Val2=0 -> `ALU_RES`=1.
- Immediate rotate: MOV, IMM=1, op=0x4FF -> `ALU_RES`=0xFF000000. With S=1 -> `SR[3]`=1, C/V unchanged.
- Register shift (EXPECTED WITH `EXE_SHIFT_EN`): MOV, IMM=0, Rm=0x80000000, op=0x240 (ASR 4) -> 0xF8000000. Without the macro -> 0x80000000.
- Branch: B_IN=1, PC_IN=0x100, imm24=0xFFFFFE -> same cycle `BRANCH_TAKEN`=1, `BRANCH_ADDR`=0x000000F8.
- Stall: SUB, S=1, Rn=5, Val2=5 with `MEM_STALL=1` for 3 edges -> outputs and SR hold previous values. Release -> one edge later `ALU_RES`=0, `SR`=4'b0110.
